// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB breathing sequencer: phase encoding and colour mask table.
package rgb_pkg;

    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_RISE = 2'd1,
        PH_HOLD = 2'd2,
        PH_FALL = 2'd3
    } phase_e;

    localparam int NUM_COLORS = 7;

    // Each entry is {b,g,r}: R, G, B, R+G, G+B, R+B, R+G+B
    localparam logic [2:0] COLOR_MASK [NUM_COLORS] = '{
        3'b001, 3'b010, 3'b100, 3'b011, 3'b110, 3'b101, 3'b111
    };

    function automatic logic [2:0] color_mask(input logic [2:0] idx);
        return (idx < 3'(NUM_COLORS)) ? COLOR_MASK[idx] : 3'b000;
    endfunction

endpackage

// File: rtl/rgb_breathe_seq_if.sv
// Control and PWM output bundle between the tick source, the sequencer and the LED driver.
interface rgb_breathe_seq_if;
    logic       en;
    logic       tick;
    logic       pwm_r;
    logic       pwm_g;
    logic       pwm_b;
    logic [2:0] color_idx;
    logic [1:0] phase;
    logic       cycle_done;

    modport master (
        output en, tick,
        input  pwm_r, pwm_g, pwm_b, color_idx, phase, cycle_done
    );

    modport slave (
        input  en, tick,
        output pwm_r, pwm_g, pwm_b, color_idx, phase, cycle_done
    );
endinterface

// File: rtl/rgb_breathe_seq_pwm_chan.sv
// One PWM channel: shadow duty register loaded at period end, compare, registered output.
module pwm_chan #(
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PWM_W-1:0] pwm_cnt,
    input  logic             load,
    input  logic [PWM_W-1:0] duty,
    input  logic             mask_en,
    output logic             pwm
);

    logic [PWM_W-1:0] shadow_q, shadow_d;
    logic             pwm_q, pwm_d;

    always_comb begin
        shadow_d = load ? duty : shadow_q;
        pwm_d    = mask_en && (pwm_cnt < shadow_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            pwm_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/rgb_breathe_seq.sv
// RGB breathing sequencer: ramp/hold/ramp duty per tick, stepping through 7 colour combinations.
// Optional square-law gamma on the compared duty when RGB_BREATHE_GAMMA_EN is defined.
module rgb_breathe_seq
    import rgb_pkg::*;
#(
    parameter int PWM_W      = 8,
    parameter int STEP       = 16,
    parameter int HOLD_TICKS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    rgb_breathe_seq_if.slave  bus
);

    localparam logic [PWM_W-1:0] DUTY_MAX = '1;
    localparam int               HW       = $clog2(HOLD_TICKS + 1);

    phase_e           state_q, state_d;
    logic [PWM_W-1:0] duty_q, duty_d;
    logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [2:0]       color_idx_q, color_idx_d;
    logic             cycle_done_q, cycle_done_d;
    logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PWM_W:0]   rise_sum;
    logic [PWM_W-1:0] cmp_duty;
    logic [2:0]       mask;
    logic             period_end;

    assign rise_sum = {1'b0, duty_q} + (PWM_W+1)'(STEP);

    always_comb begin
        state_d      = state_q;
        duty_d       = duty_q;
        hold_cnt_d   = hold_cnt_q;
        color_idx_d  = color_idx_q;
        cycle_done_d = 1'b0;
        pwm_cnt_d    = pwm_cnt_q + 1'b1;

        // Dropping enable overrides any tick in the same cycle
        if (!bus.en) begin
            state_d     = PH_IDLE;
            duty_d      = '0;
            hold_cnt_d  = '0;
            color_idx_d = '0;
        end else begin
            case (state_q)
                PH_IDLE: begin
                    state_d = PH_RISE;
                    duty_d  = '0;
                end
                PH_RISE: if (bus.tick) begin
                    if (rise_sum >= {1'b0, DUTY_MAX}) begin
                        duty_d     = DUTY_MAX;
                        hold_cnt_d = '0;
                        state_d    = PH_HOLD;
                    end else begin
                        duty_d = rise_sum[PWM_W-1:0];
                    end
                end
                PH_HOLD: if (bus.tick) begin
                    if (hold_cnt_q == HW'(HOLD_TICKS - 1)) begin
                        state_d = PH_FALL;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                PH_FALL: if (bus.tick) begin
                    if ({1'b0, duty_q} <= (PWM_W+1)'(STEP)) begin
                        duty_d  = '0;
                        state_d = PH_RISE;
                        if (color_idx_q == 3'(NUM_COLORS - 1)) begin
                            color_idx_d  = '0;
                            cycle_done_d = 1'b1;
                        end else begin
                            color_idx_d = color_idx_q + 1'b1;
                        end
                    end else begin
                        duty_d = duty_q - PWM_W'(STEP);
                    end
                end
                default: state_d = PH_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= PH_IDLE;
            duty_q       <= '0;
            hold_cnt_q   <= '0;
            color_idx_q  <= '0;
            cycle_done_q <= 1'b0;
            pwm_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            duty_q       <= duty_d;
            hold_cnt_q   <= hold_cnt_d;
            color_idx_q  <= color_idx_d;
            cycle_done_q <= cycle_done_d;
            pwm_cnt_q    <= pwm_cnt_d;
        end
    end

`ifdef RGB_BREATHE_GAMMA_EN
    localparam int DW = 2 * PWM_W;
    assign cmp_duty = PWM_W'((DW'(duty_q) * DW'(duty_q)) >> PWM_W);
`else
    assign cmp_duty = duty_q;
`endif

    assign period_end = (pwm_cnt_q == DUTY_MAX);
    assign mask       = color_mask(color_idx_q);

    pwm_chan #(.PWM_W(PWM_W)) u_chan_r (
        .clk(clk), .rst_n(rst_n), .pwm_cnt(pwm_cnt_q), .load(period_end),
        .duty(cmp_duty), .mask_en(mask[0]), .pwm(bus.pwm_r)
    );

    pwm_chan #(.PWM_W(PWM_W)) u_chan_g (
        .clk(clk), .rst_n(rst_n), .pwm_cnt(pwm_cnt_q), .load(period_end),
        .duty(cmp_duty), .mask_en(mask[1]), .pwm(bus.pwm_g)
    );

    pwm_chan #(.PWM_W(PWM_W)) u_chan_b (
        .clk(clk), .rst_n(rst_n), .pwm_cnt(pwm_cnt_q), .load(period_end),
        .duty(cmp_duty), .mask_en(mask[2]), .pwm(bus.pwm_b)
    );

    assign bus.color_idx  = color_idx_q;
    assign bus.phase      = state_q;
    assign bus.cycle_done = cycle_done_q;

endmodule

// File: tb/tb_rgb_breathe_seq.sv
// Self-checking bench for rgb_breathe_seq: table of tick bursts with expected phase/index/duty,
// plus hand-written sequences for idle output, enable drop and asynchronous reset.
module tb_rgb_breathe_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rgb_breathe_seq_if bus();

    rgb_breathe_seq #(.PWM_W(8), .STEP(16), .HOLD_TICKS(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        int ticks;
        int exp_phase;
        int exp_idx;
        int duty;
        int exp_done;
        bit chk_same;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [7:0] ref_cnt;

    // Free-running reference of the PWM period position, reset alongside the DUT
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ref_cnt <= 8'd0;
        else        ref_cnt <= ref_cnt + 8'd1;
    end

    always @(negedge clk) begin
        if (rst_n && bus.cycle_done) begin
            done_cnt++;
            checks++;
            if (bus.color_idx !== 3'd0) begin
                failures++;
                $display("[TB] FAIL done_idx actual=%0d required=0", bus.color_idx);
            end
        end
    end

    function automatic int gamma(input int d);
`ifdef RGB_BREATHE_GAMMA_EN
        return (d * d) >> 8;
`else
        return d;
`endif
    endfunction

    function automatic logic [2:0] tb_mask(input int idx);
        case (idx)
            0: return 3'b001;
            1: return 3'b010;
            2: return 3'b100;
            3: return 3'b011;
            4: return 3'b110;
            5: return 3'b101;
            6: return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) bus.tick = 1'b1;
            @(negedge clk) bus.tick = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    // Align to the start of a PWM period, then count high samples over one full period
    task automatic measure(output int hr, output int hg, output int hb, output int diff);
        int guard = 0;
        hr = 0; hg = 0; hb = 0; diff = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (ref_cnt != 8'd0 && guard < 600);
        if (guard >= 600) checkOutput("period_sync", 0, 1);
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            hr += int'(bus.pwm_r);
            hg += int'(bus.pwm_g);
            hb += int'(bus.pwm_b);
            if ((bus.pwm_r != bus.pwm_g) || (bus.pwm_g != bus.pwm_b)) diff++;
        end
    endtask

    vec_t vecs[11];

    initial begin
        int hr, hg, hb, diff, cnt;
        logic [2:0] m;

        vecs[0]  = '{ticks: 8,   exp_phase: 1, exp_idx: 0, duty: 128, exp_done: 0, chk_same: 1'b0};
        vecs[1]  = '{ticks: 7,   exp_phase: 1, exp_idx: 0, duty: 240, exp_done: 0, chk_same: 1'b0};
        vecs[2]  = '{ticks: 1,   exp_phase: 2, exp_idx: 0, duty: 255, exp_done: 0, chk_same: 1'b0};
        vecs[3]  = '{ticks: 31,  exp_phase: 2, exp_idx: 0, duty: 255, exp_done: 0, chk_same: 1'b0};
        vecs[4]  = '{ticks: 1,   exp_phase: 3, exp_idx: 0, duty: 255, exp_done: 0, chk_same: 1'b0};
        vecs[5]  = '{ticks: 15,  exp_phase: 3, exp_idx: 0, duty: 15,  exp_done: 0, chk_same: 1'b0};
        vecs[6]  = '{ticks: 1,   exp_phase: 1, exp_idx: 1, duty: 0,   exp_done: 0, chk_same: 1'b0};
        vecs[7]  = '{ticks: 8,   exp_phase: 1, exp_idx: 1, duty: 128, exp_done: 0, chk_same: 1'b0};
        vecs[8]  = '{ticks: 56,  exp_phase: 1, exp_idx: 2, duty: 0,   exp_done: 0, chk_same: 1'b0};
        vecs[9]  = '{ticks: 264, exp_phase: 1, exp_idx: 6, duty: 128, exp_done: 0, chk_same: 1'b1};
        vecs[10] = '{ticks: 56,  exp_phase: 1, exp_idx: 0, duty: 0,   exp_done: 1, chk_same: 1'b0};

        bus.en = 1'b0;
        bus.tick = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_phase", int'(bus.phase), 0);
        checkOutput("reset_idx", int'(bus.color_idx), 0);
        checkOutput("reset_pwm", int'({bus.pwm_b, bus.pwm_g, bus.pwm_r}), 0);
        checkOutput("reset_done", int'(bus.cycle_done), 0);

        bus.en = 1'b1;
        @(negedge clk);
        checkOutput("idle_to_rise", int'(bus.phase), 1);
        cnt = 0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            cnt += int'(bus.pwm_r) + int'(bus.pwm_g) + int'(bus.pwm_b);
        end
        checkOutput("no_tick_pwm_high", cnt, 0);
        checkOutput("no_tick_phase", int'(bus.phase), 1);

        for (int v = 0; v < 11; v++) begin
            applyStimulus(vecs[v].ticks);
            checkOutput($sformatf("v%0d_phase", v), int'(bus.phase), vecs[v].exp_phase);
            checkOutput($sformatf("v%0d_idx", v), int'(bus.color_idx), vecs[v].exp_idx);
            measure(hr, hg, hb, diff);
            m = tb_mask(vecs[v].exp_idx);
            checkOutput($sformatf("v%0d_high_r", v), hr, m[0] ? gamma(vecs[v].duty) : 0);
            checkOutput($sformatf("v%0d_high_g", v), hg, m[1] ? gamma(vecs[v].duty) : 0);
            checkOutput($sformatf("v%0d_high_b", v), hb, m[2] ? gamma(vecs[v].duty) : 0);
            checkOutput($sformatf("v%0d_done_count", v), done_cnt, vecs[v].exp_done);
            if (vecs[v].chk_same) checkOutput($sformatf("v%0d_rgb_differ", v), diff, 0);
        end

        // Bring green to duty 128, then drop enable in the same cycle as a tick
        applyStimulus(72);
        measure(hr, hg, hb, diff);
        checkOutput("pre_drop_idx", int'(bus.color_idx), 1);
        checkOutput("pre_drop_high_g", hg, gamma(128));
        @(negedge clk);
        bus.tick = 1'b1;
        bus.en = 1'b0;
        @(negedge clk);
        bus.tick = 1'b0;
        checkOutput("drop_phase", int'(bus.phase), 0);
        checkOutput("drop_idx", int'(bus.color_idx), 0);
        repeat (257) @(negedge clk);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            cnt += int'(bus.pwm_r) + int'(bus.pwm_g) + int'(bus.pwm_b);
        end
        checkOutput("drop_pwm_high", cnt, 0);

        // Red at duty 128, then pull reset mid-cycle while the output is high
        bus.en = 1'b1;
        @(negedge clk);
        applyStimulus(8);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (ref_cnt != 8'd0 && cnt < 600);
        if (cnt >= 600) checkOutput("period_sync", 0, 1);
        repeat (10) @(negedge clk);
        checkOutput("pre_reset_pwm_r", int'(bus.pwm_r), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_pwm", int'({bus.pwm_b, bus.pwm_g, bus.pwm_r}), 0);
        checkOutput("async_reset_phase", int'(bus.phase), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.en = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
